// File: rtl/airplane_pkg.sv
// Shared types and sprite geometry for the airplane sprite controller.
package airplane_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_LOAD_E,
    S_ERASE,
    S_MOVE,
    S_LOAD_D,
    S_DRAW
  } state_e;

  localparam int SPRITE_W = 8;
  localparam int SPRITE_H = 4;
  localparam int SCREEN_H = 120;
  localparam int PIX_W    = $clog2(SPRITE_W * SPRITE_H);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(SPRITE_W * SPRITE_H - 1);

endpackage

// File: rtl/airplane_control_frame_tick.sv
// Free-running frame divider: counts 0..FRAME_TICKS-1 and pulses tick on the wrap cycle.
module frame_tick #(
  parameter int FRAME_TICKS = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(FRAME_TICKS);
  localparam logic [CW-1:0] LAST = CW'(FRAME_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/airplane_control.sv
// Airplane sprite controller: per frame erases the 8x4 sprite, moves it, redraws it.
// Optional AIRPLANE_GRAVITY_EN makes an idle plane sink one row every 4th frame.
module airplane_control
  import airplane_pkg::*;
#(
  parameter int FRAME_TICKS = 833333,
  parameter int Y_START     = 58,
  parameter int Y_MAX       = 116
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up,
  input  logic             down,
  output logic             ld_x,
  output logic             ld_y,
  output logic             ld_color,
  output logic             erase,
  output logic             enable,
  output logic             draw,
  output logic [PIX_W-1:0] pix_cnt,
  output logic [6:0]       plane_y,
  output logic             busy
);

  localparam logic [6:0] Y0   = 7'(Y_START);
  localparam logic [6:0] YTOP = 7'(Y_MAX);

  state_e           state_q;
  logic [PIX_W-1:0] pix_q;
  logic [6:0]       y_q, y_d;
  logic             pend_q;
  logic             tick;
  logic             pix_last;
  logic             sweep;
  logic             ld;

  frame_tick #(.FRAME_TICKS(FRAME_TICKS)) u_frame_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign pix_last = (pix_q == PIX_LAST);

`ifdef AIRPLANE_GRAVITY_EN
  logic [1:0] grav_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 grav_q <= 2'd0;
    else if (state_q == S_MOVE) grav_q <= grav_q + 2'd1;
  end
`endif

  always_comb begin
    y_d = y_q;
    if (up && !down)
      y_d = (y_q == 7'd0) ? y_q : y_q - 7'd1;
    else if (down && !up)
      y_d = (y_q >= YTOP) ? YTOP : y_q + 7'd1;
`ifdef AIRPLANE_GRAVITY_EN
    else if (!up && !down && grav_q == 2'd3)
      y_d = (y_q >= YTOP) ? YTOP : y_q + 7'd1;
`endif
  end

  // Reset parks in S_LOAD_D so the first pass after release draws without erasing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LOAD_D;
      pix_q   <= '0;
      y_q     <= Y0;
      pend_q  <= 1'b0;
    end else begin
      if (state_q != S_WAIT && tick) pend_q <= 1'b1;
      unique case (state_q)
        S_WAIT: if (tick || pend_q) begin
          state_q <= S_LOAD_E;
          pend_q  <= 1'b0;
        end
        S_LOAD_E: state_q <= S_ERASE;
        S_ERASE: begin
          pix_q <= pix_last ? '0 : pix_q + PIX_W'(1);
          if (pix_last) state_q <= S_MOVE;
        end
        S_MOVE: begin
          y_q     <= y_d;
          state_q <= S_LOAD_D;
        end
        S_LOAD_D: state_q <= S_DRAW;
        S_DRAW: begin
          pix_q <= pix_last ? '0 : pix_q + PIX_W'(1);
          if (pix_last) state_q <= S_WAIT;
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  // Outputs decode the registered state; load strobes are masked while reset holds S_LOAD_D.
  assign sweep    = (state_q == S_ERASE) || (state_q == S_DRAW);
  assign ld       = !reset && ((state_q == S_LOAD_E) || (state_q == S_LOAD_D));
  assign ld_x     = ld;
  assign ld_y     = ld;
  assign ld_color = ld;
  assign draw     = sweep;
  assign enable   = sweep;
  assign erase    = (state_q == S_LOAD_E) || (state_q == S_ERASE);
  assign busy     = (state_q != S_WAIT);
  assign pix_cnt  = pix_q;
  assign plane_y  = y_q;

endmodule
